mult_sched: RTL and testbench
=============================

# mult_sched

Two-requester scheduler that shares one 4x4 sequential multiplier core. Each requester presents a pair of 4-bit factors with a valid/ready handshake. The block arbitrates round-robin, latches the winner's operands and pulses the core's start. It then waits for the core's done flag, with a timeout, and returns the 8-bit product, or an error, to the requester that was granted. It sits between the client logic and the multiplier core and is the only driver of the core's start and factor inputs.

## Interface
- TIMEOUT, 15: maximum WAIT cycles before the operation is aborted with an error. Legal range is 2..31; the wait counter is 5 bits.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request; bit i belongs to requester i
- req_a0, req_b0  in  4 each  factors from requester 0
- req_a1, req_b1  in  4 each  factors from requester 1
- req_ready  out  2  one-hot acceptance; combinational
- resp_valid  out  2  one-cycle response pulse to the granted requester
- resp_data  out  8  product; meaningful only while resp_valid is nonzero
- resp_err  out  1  timeout flag, qualifies resp_valid
- busy  out  1  high in every state except IDLE
- mul_start  out  1  start pulse to the multiplier core
- mul_dataa, mul_datab  out  4 each  latched factors, held stable from ISSUE through WAIT
- mul_done  in  1  done flag from the core; may remain high after an operation
- mul_product  in  8  product from the core

## Operation
- States and transitions:
  - IDLE -> ISSUE on accept.
  - ISSUE -> WAIT unconditionally.
  - WAIT -> RESP when done is seen or the timeout is reached.
  - RESP -> IDLE unconditionally.
- Arbitration:
  - Pointer `last` holds the index of the last served requester; reset value is 1, so requester 0 wins first.
  - In IDLE, if only one req_valid bit is set, that requester is granted.
  - If both bits are set, the requester other than `last` is granted.
  - req_ready = grant one-hot in IDLE, 0 in all other states.
  - Accept = req_valid[i] & req_ready[i] at a clock edge.
- On accept:
  - The granted factors are latched into mul_dataa/mul_datab.
  - Grant index g is latched.
  - `last` is set to g.
- ISSUE: mul_start=1 for exactly one cycle; the wait counter is cleared to 0.
- WAIT:
  - The counter increments each cycle.
  - mul_done is ignored while the counter is 0. This masks a done flag left high from the previous operation.
  - When mul_done=1 and the counter is ≥1: mul_product is captured into the resp_data register, resp_err=0, go to RESP.
  - When the counter = TIMEOUT and done has not been seen: resp_data=0x00, resp_err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins: no error.
- RESP: resp_valid[g]=1 for one cycle, then IDLE. Responses cannot be back-pressured.
- Requests:
  - Requests asserted outside IDLE wait; req_valid must be held with stable factors until accepted.
  - Dropping req_valid before acceptance is legal; the request is then simply never served.
- Arithmetic:
  - The product is unsigned, 4x4->8, taken verbatim from mul_product; no recomputation.
  - The counter saturates logic-wise at TIMEOUT and never wraps.

## Timing
- Reset values: state=IDLE, last=1, req_ready=2'b00 until a request arrives, resp_valid=0, resp_data=0, resp_err=0, busy=0, mul_start=0, mul_dataa=0, mul_datab=0.
- Reset asserted mid-operation (ISSUE/WAIT/RESP):
  - Everything returns to reset values immediately (async).
  - No response is issued for the aborted operation.
  - mul_start drops at once.
- Per-operation cycle sequence:
  - Edge E0: accept.
  - Cycle after E0: ISSUE, with mul_start=1.
  - Cycle after E1: WAIT, counter 0.
  - The first done sample is one cycle later.
  - RESP is the cycle after done is sampled.
- Minimum accept-to-resp_valid latency is 4 cycles.
- Minimum spacing between accepts is 5 cycles.
- Worst case: accept at E0, RESP TIMEOUT+3 cycles after E0 with resp_err=1.
- busy rises the cycle after accept and falls on entry to IDLE. The next accept can happen in the first IDLE cycle.
- resp_data/resp_err hold their values until the next RESP; only resp_valid is pulsed.

## Test plan
- Single request: requester 0 sends 3×5; core model raises done 4 cycles after start with product 15 -> one accept, mul_start pulses once, resp_valid=2'b01, resp_data=0x0F, resp_err=0.
- Contention: both requesters valid from reset, requester 0 with 7×9 and requester 1 with 15×15 -> requester 0 is served first with 0x3F, then requester 1 with 0xE1. With both held valid, grants alternate 0,1,0,1.
- Stale done: core model holds mul_done=1 continuously from the previous operation -> it is ignored in the first WAIT cycle; the response arrives at the earliest legal cycle with the product of the new operands.
- Timeout: mul_done tied to 0, requester 1 sends 2×2 -> resp_valid=2'b10 exactly TIMEOUT+3 cycles after accept, resp_err=1, resp_data=0x00. The next request is served normally.
- Reset mid-WAIT: rst_n asserted low for one cycle during WAIT -> all outputs return to reset values the same cycle, no resp_valid is issued, and the next grant goes to requester 0.
- Operand stability: requester changes its factors after accept -> mul_dataa/mul_datab keep the latched values until the next accept.

Source files
------------

// File: rtl/mult_sched.sv
// Round-robin scheduler that lets two requesters share one 4x4 sequential
// multiplier core, with a done-timeout and a one-cycle response pulse.
module mult_sched #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b1,
    output logic [1:0] req_ready,
    output logic [1:0] resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_err,
    output logic       busy,
    output logic       mul_start,
    output logic [3:0] mul_dataa,
    output logic [3:0] mul_datab,
    input  logic       mul_done,
    input  logic [7:0] mul_product
);

    localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic        last_q,       last_d;
    logic        gnt_q,        gnt_d;
    logic [4:0]  cnt_q,        cnt_d;
    logic [3:0]  dataa_q,      dataa_d;
    logic [3:0]  datab_q,      datab_d;
    logic        start_q,      start_d;
    logic [1:0]  resp_valid_q, resp_valid_d;
    logic [7:0]  resp_data_q,  resp_data_d;
    logic        resp_err_q,   resp_err_d;
    logic        busy_q,       busy_d;

    logic [1:0]  grant_s;
    logic        accept_s;
    logic        gnt_idx_s;
    logic        done_seen_s;
    logic        timeout_s;

    // Both requesters pending: serve the one that was not served last.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
        logic [1:0] pick;
        pick = 2'b00;
        case (valid)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

    // Combinational grant, only offered while idle.
    always_comb begin
        grant_s = 2'b00;
        if (state_q == S_IDLE) begin
            grant_s = rr_pick(req_valid, last_q);
        end else begin
            grant_s = 2'b00;
        end
    end

    assign accept_s  = |(req_valid & grant_s);
    assign gnt_idx_s = grant_s[1];

    // A done left high by the previous operation is masked in the first WAIT cycle.
    assign done_seen_s = mul_done & (cnt_q != 5'd0);
    assign timeout_s   = (cnt_q >= TIMEOUT_C);

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        dataa_d      = dataa_q;
        datab_d      = datab_q;
        start_d      = 1'b0;
        resp_valid_d = 2'b00;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        busy_d       = busy_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_ISSUE;
                    last_d  = gnt_idx_s;
                    gnt_d   = gnt_idx_s;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    if (gnt_idx_s) begin
                        dataa_d = req_a1;
                        datab_d = req_b1;
                    end else begin
                        dataa_d = req_a0;
                        datab_d = req_b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = 5'd0;
            end
            S_WAIT: begin
                if (done_seen_s || timeout_s) begin
                    state_d = S_RESP;
                    if (gnt_q) begin
                        resp_valid_d = 2'b10;
                    end else begin
                        resp_valid_d = 2'b01;
                    end
                    // Done wins over a simultaneous timeout.
                    if (done_seen_s) begin
                        resp_data_d = mul_product;
                        resp_err_d  = 1'b0;
                    end else begin
                        resp_data_d = 8'h00;
                        resp_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= 5'd0;
            dataa_q      <= 4'd0;
            datab_q      <= 4'd0;
            start_q      <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= 8'h00;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            dataa_q      <= dataa_d;
            datab_q      <= datab_d;
            start_q      <= start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = grant_s;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign mul_start  = start_q;
    assign mul_dataa  = dataa_q;
    assign mul_datab  = datab_q;

endmodule

// File: tb/tb_mult_sched.sv
// Directed, table-driven bench for mult_sched with a small behavioural
// multiplier-core model (programmable done delay, stale done, stuck-low done).
module tb_mult_sched;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [3:0] req_a0 = 4'd0, req_b0 = 4'd0, req_a1 = 4'd0, req_b1 = 4'd0;
    logic [1:0] req_ready, resp_valid;
    logic [7:0] resp_data;
    logic       resp_err, busy, mul_start;
    logic [3:0] mul_dataa, mul_datab;
    logic       mul_done = 1'b0;
    logic [7:0] mul_product = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;

    int done_delay = 2;
    bit stale_mode = 1'b0;
    bit tie_low = 1'b0;
    logic [3:0] dly = 4'd0;
    logic [7:0] prod_pend = 8'h00;

    mult_sched #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .mul_start(mul_start),
        .mul_dataa(mul_dataa), .mul_datab(mul_datab),
        .mul_done(mul_done), .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mul_start) start_cnt <= start_cnt + 1;

    // Core model: done rises done_delay cycles after the start cycle and stays high.
    always @(posedge clk) begin
        if (mul_start) begin
            dly       <= 4'(done_delay - 1);
            prod_pend <= {4'd0, mul_dataa} * {4'd0, mul_datab};
            if (stale_mode) mul_product <= {4'd0, mul_dataa} * {4'd0, mul_datab};
            else            mul_done    <= 1'b0;
        end else if (dly != 4'd0) begin
            dly <= dly - 4'd1;
            if (dly == 4'd1 && !tie_low) begin
                mul_done    <= 1'b1;
                mul_product <= prod_pend;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; drives a request, waits for accept and response.
    task automatic run_op(input logic [1:0] valid, input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1, input int delay,
                          input bit stale, input bit tiel, input bit hold,
                          input logic [1:0] exp_gnt, input logic [7:0] exp_data,
                          input logic exp_err, input int exp_lat, input string tag);
        int acc_cyc = 0;
        int s0;
        logic [1:0] g = 2'b00;
        bit got = 1'b0;
        req_valid = valid; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        done_delay = delay; stale_mode = stale; tie_low = tiel;
        s0 = start_cnt;
        #1;
        for (int i = 0; i < 10 && !got; i++) begin
            if ((req_valid & req_ready) != 2'b00) begin
                g = req_valid & req_ready; got = 1'b1; acc_cyc = cyc;
            end else begin
                @(negedge clk); #1;
            end
        end
        check({tag, ".grant"}, {30'd0, g}, {30'd0, exp_gnt});
        @(negedge clk);
        if (!hold) req_valid = 2'b00;
        #1;
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".ready_busy"}, {30'd0, req_ready}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (resp_valid != 2'b00) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, ".resp_valid"}, {30'd0, resp_valid}, {30'd0, exp_gnt});
        check({tag, ".resp_data"}, {24'd0, resp_data}, {24'd0, exp_data});
        check({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, ".latency"}, cyc - acc_cyc, exp_lat);
        check({tag, ".starts"}, start_cnt - s0, 32'd1);
        @(negedge clk);
        check({tag, ".pulse_end"}, {30'd0, resp_valid}, 32'd0);
        check({tag, ".data_hold"}, {24'd0, resp_data}, {24'd0, exp_data});
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Reset pulse starting at a negedge; outputs checked while reset is low.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".start"}, {31'd0, mul_start}, 32'd0);
        check({tag, ".dataa"}, {28'd0, mul_dataa}, 32'd0);
        check({tag, ".datab"}, {28'd0, mul_datab}, 32'd0);
        check({tag, ".resp_valid"}, {30'd0, resp_valid}, 32'd0);
        check({tag, ".resp_data"}, {24'd0, resp_data}, 32'd0);
        check({tag, ".resp_err"}, {31'd0, resp_err}, 32'd0);
        check({tag, ".ready"}, {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [3:0] a0, b0, a1, b1;
        int         delay;
        bit         stale;
        logic [1:0] exp_gnt;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit seen;
        // Latency = done_delay + 2 for a fresh done; 4 when a stale done is already high.
        vecs[0] = '{2'b01, 4'd3,  4'd5,  4'd0,  4'd0,  4, 1'b0, 2'b01, 8'h0F, 6};
        vecs[1] = '{2'b10, 4'd0,  4'd0,  4'd6,  4'd7,  2, 1'b0, 2'b10, 8'h2A, 4};
        vecs[2] = '{2'b11, 4'd7,  4'd9,  4'd15, 4'd15, 3, 1'b0, 2'b01, 8'h3F, 5};
        vecs[3] = '{2'b11, 4'd7,  4'd9,  4'd15, 4'd15, 2, 1'b0, 2'b10, 8'hE1, 4};
        vecs[4] = '{2'b01, 4'd15, 4'd15, 4'd0,  4'd0,  2, 1'b1, 2'b01, 8'hE1, 4};
        vecs[5] = '{2'b10, 4'd0,  4'd0,  4'd0,  4'd9,  6, 1'b0, 2'b10, 8'h00, 8};
        vecs[6] = '{2'b01, 4'd12, 4'd11, 4'd0,  4'd0,  2, 1'b1, 2'b01, 8'h84, 4};

        repeat (2) @(negedge clk);
        reset_pulse("reset");

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                   vecs[i].delay, vecs[i].stale, 1'b0, 1'b0, vecs[i].exp_gnt,
                   vecs[i].exp_data, 1'b0, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Contention from reset with both held valid: grants alternate 0,1,0,1.
        reset_pulse("reset2");
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 4'd7, 4'd9, 4'd15, 4'd15, 3, 1'b0, 1'b0, 1'b1,
                   (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'h3F : 8'hE1,
                   1'b0, 5, $sformatf("rr%0d", i));
        end
        req_valid = 2'b00;

        // Timeout, then a normal operation afterwards.
        run_op(2'b10, 4'd0, 4'd0, 4'd2, 4'd2, 2, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 1'b1, TMO + 3, "tmo");
        run_op(2'b10, 4'd0, 4'd0, 4'd2, 4'd2, 3, 1'b0, 1'b0, 1'b0, 2'b10, 8'h04, 1'b0, 5, "after_tmo");

        // Reset mid-WAIT: requester 0 served last, so only a reset makes 0 win next.
        run_op(2'b01, 4'd4, 4'd4, 4'd0, 4'd0, 2, 1'b0, 1'b0, 1'b0, 2'b01, 8'h10, 1'b0, 4, "pre_rst");
        tie_low = 1'b1; stale_mode = 1'b0;
        req_valid = 2'b01; req_a0 = 4'd5; req_b0 = 4'd5;
        #1;
        check("rst_wait.ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        check("rst_wait.start", {31'd0, mul_start}, 32'd1);
        repeat (2) @(negedge clk);
        check("rst_wait.busy_before", {31'd0, busy}, 32'd1);
        reset_pulse("rst_wait");
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) seen = 1'b1;
        end
        check("rst_wait.no_resp", {31'd0, seen}, 32'd0);
        tie_low = 1'b0;
        run_op(2'b11, 4'd7, 4'd9, 4'd15, 4'd15, 2, 1'b0, 1'b0, 1'b0, 2'b01, 8'h3F, 1'b0, 4, "post_rst");

        // Operand stability: factors change right after accept.
        done_delay = 3; stale_mode = 1'b0;
        req_valid = 2'b01; req_a0 = 4'd5; req_b0 = 4'd6;
        #1;
        check("stab.ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00; req_a0 = 4'd9; req_b0 = 4'd1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            check("stab.dataa", {28'd0, mul_dataa}, 32'd5);
            check("stab.datab", {28'd0, mul_datab}, 32'd6);
            if (resp_valid != 2'b00) seen = 1'b1;
            else @(negedge clk);
        end
        check("stab.resp_data", {24'd0, resp_data}, 32'h1E);
        repeat (2) @(negedge clk);
        check("stab.dataa_idle", {28'd0, mul_dataa}, 32'd5);
        check("stab.datab_idle", {28'd0, mul_datab}, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
